// File: rtl/rr_select16.sv
// rtl/rr_select16.sv - round-robin arbiter driving a 16:1 mux select with valid/ready handoff
// sel and out_valid are registered; grant is the combinational acceptance pulse.
module rr_select16 #(
  parameter logic [3:0] RESET_LAST = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic        out_valid,
  output logic [15:0] grant,
  output logic [3:0]  last
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_d;
  logic [3:0]  sel_d;
  logic [3:0]  last_d;
  logic [15:0] masked;

  // First set bit of r searching from+1, from+2, ... wrapping in 4 bits.
  function automatic logic [3:0] winner(input logic [15:0] r, input logic [3:0] from);
    logic [3:0] idx;
    logic       found;
    winner = 4'd0;
    found  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = from + 4'(i);
      if (!found && r[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign out_valid = (state == BUSY);
  assign masked    = req & ~(16'b1 << sel);
  assign grant     = (out_valid && out_ready) ? (16'b1 << sel) : 16'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 4'd0;
      last  <= RESET_LAST;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      last  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    last_d  = last;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_d   = winner(req, last);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Backpressure holds sel; arbitration only moves on acceptance.
        if (out_ready) begin
          last_d = sel;
          if (|masked) sel_d = winner(masked, sel);
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_select16.sv
// tb/tb_rr_select16.sv - scoreboard bench for rr_select16 with a priority-search reference model
module tb_rr_select16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic        out_valid;
  logic [15:0] grant;
  logic [3:0]  last;

  rr_select16 dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .sel(sel), .out_valid(out_valid), .grant(grant), .last(last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  s;
    logic [15:0] g;
    logic [3:0]  l;
    bit          cs;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: a plain "who is being offered" view of the arbiter.
  bit known = 0;
  bit m_busy = 0;
  bit m_just_reset = 0;
  int m_sel = 0;
  int m_last = 15;
  string phase = "reset";

  function automatic int search(input logic [15:0] r, input int from);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      idx = (from + k) % 16;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Applies the inputs sampled at the edge that just happened to the model.
  task automatic model_edge();
    logic [15:0] m;
    if (rst) begin
      known = 1; m_busy = 0; m_sel = 0; m_last = 15; m_just_reset = 1;
    end else if (known) begin
      m_just_reset = 0;
      if (!m_busy) begin
        if (req != 16'h0) begin
          m_sel = search(req, m_last);
          m_busy = 1;
        end
      end else if (out_ready) begin
        m_last = m_sel;
        m = req;
        m[m_sel] = 1'b0;
        if (m != 16'h0) m_sel = search(m, m_last);
        else m_busy = 0;
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic [15:0] req_v, input logic rdy_v);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    if (m_busy && !rst_v) req_v[m_sel] = 1'b1;
    rst = rst_v; req = req_v; out_ready = rdy_v;
    if (known) begin
      e.v   = m_busy;
      e.s   = 4'(m_sel);
      e.g   = (m_busy && rdy_v) ? (16'h1 << m_sel) : 16'h0;
      e.l   = 4'(m_last);
      e.cs  = m_busy || m_just_reset;
      e.tag = phase;
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
        chk({e.tag, ".grant"}, 32'(grant), 32'(e.g));
        chk({e.tag, ".last"}, 32'(last), 32'(e.l));
        if (e.cs) chk({e.tag, ".sel"}, 32'(sel), 32'(e.s));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] r;
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b0;

    phase = "reset";
    step(1, 16'hFFFF, 0);
    step(1, 16'hFFFF, 0);
    step(0, 16'hFFFF, 0);
    phase = "rotation";
    for (int i = 0; i < 18; i++) step(0, 16'hFFFF, 1);

    phase = "wrap";
    step(1, 16'h0000, 0);
    step(0, 16'h2000, 1);
    step(0, 16'h2000, 1);
    step(0, 16'h0005, 1);
    step(0, 16'h0005, 1);
    step(0, 16'h0004, 1);
    step(0, 16'h0000, 1);

    phase = "backpressure";
    step(1, 16'h0000, 0);
    step(0, 16'h0090, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0090, 0);
    step(0, 16'h0090, 1);
    step(0, 16'h0080, 1);
    step(0, 16'h0000, 1);

    phase = "single";
    step(1, 16'h0000, 0);
    for (int i = 0; i < 7; i++) step(0, 16'h0100, 1);

    phase = "reset_mid";
    step(1, 16'h0000, 0);
    step(0, 16'h0020, 0);
    step(0, 16'h0020, 0);
    step(1, 16'h0020, 0);
    step(0, 16'h0020, 0);
    step(0, 16'h0000, 0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: r = 16'h1 << $urandom_range(0, 15);
        2: r = 16'($urandom);
        default: r = 16'h0;
      endcase
      step(($urandom_range(0, 49) == 0), r, 1'($urandom));
    end

    phase = "drain";
    step(1, 16'h0000, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
